// File: rtl/mac_job_scheduler.sv
// Round-robin dot-product job scheduler sharing one pipelined multiplier.
// Define MAC_SCHED_SAT_EN for saturating (instead of wrapping) accumulation.
module mac_job_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_INPUTS   = 4,
    parameter int PIXEL_WIDTH  = 10,
    parameter int WEIGHT_WIDTH = 19,
    parameter int OUTPUT_WIDTH = 26,
    parameter int MULT_LATENCY = 1,
    parameter int ID_WIDTH     = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*NUM_INPUTS*PIXEL_WIDTH-1:0] req_pixels,
    input  logic [NUM_REQ*NUM_INPUTS*WEIGHT_WIDTH-1:0] req_weights,
    output logic [PIXEL_WIDTH-1:0]                    mac_pixel,
    output logic [WEIGHT_WIDTH-1:0]                   mac_weight,
    output logic                                      mac_op_valid,
    input  logic [OUTPUT_WIDTH-1:0]                   mac_product,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [OUTPUT_WIDTH-1:0]                   res_data,
    output logic [ID_WIDTH-1:0]                       res_id
);
    localparam int PV_W   = NUM_INPUTS * PIXEL_WIDTH;
    localparam int WV_W   = NUM_INPUTS * WEIGHT_WIDTH;
    localparam int STEP_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int DRN_W  = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_INPUTS - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(MULT_LATENCY - 1);
    localparam int MSB = OUTPUT_WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_WIDTH-1:0]     r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ID_WIDTH-1:0]     w_gid;
    logic [NUM_REQ-1:0]      w_grant;
    logic                    w_found;
    logic                    w_accept;
    logic                    w_pvalid;
    logic [PV_W-1:0]         r_pix;
    logic [WV_W-1:0]         r_wgt;
    logic [STEP_W-1:0]       r_step;
    logic [DRN_W-1:0]        r_drn;
    logic [MULT_LATENCY-1:0] r_vdly;
    logic [OUTPUT_WIDTH-1:0] r_acc;
    logic [OUTPUT_WIDTH-1:0] w_sum;
    logic [OUTPUT_WIDTH-1:0] w_acc_nxt;

    // First asserted request searching upward from last_grant+1, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_gid   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(r_last) + i) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found      = 1'b1;
                w_gid        = ID_WIDTH'(idx);
                w_grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);

    always_comb begin
        mac_op_valid = (r_state == S_ISSUE);
        mac_pixel    = '0;
        mac_weight   = '0;
        if (mac_op_valid) begin
            mac_pixel  = r_pix[r_step*PIXEL_WIDTH +: PIXEL_WIDTH];
            mac_weight = r_wgt[r_step*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

    assign w_pvalid = r_vdly[MULT_LATENCY-1];
    assign w_sum    = r_acc + mac_product;

`ifdef MAC_SCHED_SAT_EN
    logic w_ovf;
    assign w_ovf = (r_acc[MSB] == mac_product[MSB]) && (w_sum[MSB] != r_acc[MSB]);
    assign w_acc_nxt = !w_ovf     ? w_sum :
                       r_acc[MSB] ? {1'b1, {MSB{1'b0}}} :
                                    {1'b0, {MSB{1'b1}}};
`else
    assign w_acc_nxt = w_sum;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_step == STEP_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drn == DRN_LAST) w_state_nxt = S_HOLD;
            S_HOLD:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= ID_WIDTH'(NUM_REQ - 1);
            r_id    <= '0;
            r_pix   <= '0;
            r_wgt   <= '0;
            r_step  <= '0;
            r_drn   <= '0;
            r_vdly  <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vdly  <= MULT_LATENCY'({r_vdly, mac_op_valid});
            if (w_accept) begin
                r_id   <= w_gid;
                r_last <= w_gid;
                r_pix  <= req_pixels[w_gid*PV_W +: PV_W];
                r_wgt  <= req_weights[w_gid*WV_W +: WV_W];
                r_acc  <= '0;
                r_step <= '0;
            end else if (w_pvalid) begin
                r_acc <= w_acc_nxt;
            end
            if (r_state == S_ISSUE) begin
                r_step <= r_step + STEP_W'(1);
                r_drn  <= '0;
            end else if (r_state == S_DRAIN) begin
                r_drn <= r_drn + DRN_W'(1);
            end
        end
    end

    assign res_valid = (r_state == S_HOLD);
    assign res_data  = r_acc;
    assign res_id    = r_id;

endmodule
